// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: receives set-2 scan-code frames, tracks make/break,
// E0 prefix, Shift and Caps Lock, and emits translated ASCII with a kdone strobe.
// Optional build macro PS2_NOREPEAT_EN suppresses typematic repeats of the last make.
module ps2_keyboard #(
  parameter int unsigned TIMEOUT_CYC = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       kdone,
  output logic [7:0] ascii,
  output logic       err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  logic            clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
  logic            fall;
  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            byte_valid, rx_err;

  logic            ext_q, ext_d, rel_q, rel_d, shift_q, shift_d, caps_q, caps_d;
  logic            kdone_q, kdone_d, err_q;
  logic [7:0]      ascii_q, ascii_d;
  logic [7:0]      code;
  logic [8:0]      map_res;
  logic            rpt_hit;
`ifdef PS2_NOREPEAT_EN
  logic [7:0]      last_code_q, last_code_d;
  logic            last_ext_q, last_ext_d, last_v_q, last_v_d;
`endif

  // Two-flop synchronisers plus a history flop for clock falling-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat;
      dat_sync <= dat_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

  // Receiver state and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
    end
  end

  // Receiver next state: frame bits on falling edges, mid-frame inactivity timeout
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tmo_d      = '0;
    byte_valid = 1'b0;
    rx_err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          if (!dat_sync) begin
            state_d   = StData;
            bit_cnt_d = '0;
            par_d     = 1'b0;
          end else begin
            rx_err = 1'b1;
          end
        end
      end
      StData: begin
        if (fall) begin
          shreg_d   = {dat_sync, shreg_q[7:1]};
          par_d     = par_q ^ dat_sync;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = par_q ^ dat_sync;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          // par_q is 1 exactly when data plus parity bit hold an odd number of ones
          if (dat_sync && par_q) byte_valid = 1'b1;
          else                   rx_err     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle && !fall) begin
      if (tmo_q == TmoLast) begin
        state_d = StIdle;
        rx_err  = 1'b1;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  // Set-2 to ASCII translation; bit 8 flags a mapped key
  function automatic logic [8:0] key_map(input logic [7:0] sc, input logic ext,
                                         input logic upper, input logic shifted);
    logic [7:0] letter;
    key_map = '0;
    letter  = '0;
    if (ext) begin
      case (sc)
        8'h75:   key_map = {1'b1, 8'h80};
        8'h72:   key_map = {1'b1, 8'h81};
        8'h6B:   key_map = {1'b1, 8'h82};
        8'h74:   key_map = {1'b1, 8'h83};
        8'h5A:   key_map = {1'b1, 8'h0D};
        default: key_map = '0;
      endcase
    end else begin
      case (sc)
        8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
        8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
        8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
        8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
        8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
        8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
        8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
        8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
        8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
        8'h45: key_map = {1'b1, shifted ? 8'h29 : 8'h30};
        8'h16: key_map = {1'b1, shifted ? 8'h21 : 8'h31};
        8'h1E: key_map = {1'b1, shifted ? 8'h40 : 8'h32};
        8'h26: key_map = {1'b1, shifted ? 8'h23 : 8'h33};
        8'h25: key_map = {1'b1, shifted ? 8'h24 : 8'h34};
        8'h2E: key_map = {1'b1, shifted ? 8'h25 : 8'h35};
        8'h36: key_map = {1'b1, shifted ? 8'h5E : 8'h36};
        8'h3D: key_map = {1'b1, shifted ? 8'h26 : 8'h37};
        8'h3E: key_map = {1'b1, shifted ? 8'h2A : 8'h38};
        8'h46: key_map = {1'b1, shifted ? 8'h28 : 8'h39};
        8'h29: key_map = {1'b1, 8'h20};
        8'h5A: key_map = {1'b1, 8'h0D};
        8'h66: key_map = {1'b1, 8'h08};
        8'h0D: key_map = {1'b1, 8'h09};
        8'h76: key_map = {1'b1, 8'h1B};
        default: letter = '0;
      endcase
      if (letter != 8'h00) key_map = {1'b1, upper ? letter - 8'h20 : letter};
    end
  endfunction

  assign code    = shreg_q;
  assign map_res = key_map(code, ext_q, shift_q ^ caps_q, shift_q);

  // Decoder and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      shift_q <= 1'b0;
      caps_q  <= 1'b0;
      kdone_q <= 1'b0;
      err_q   <= 1'b0;
      ascii_q <= 8'h00;
`ifdef PS2_NOREPEAT_EN
      last_code_q <= 8'h00;
      last_ext_q  <= 1'b0;
      last_v_q    <= 1'b0;
`endif
    end else begin
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      shift_q <= shift_d;
      caps_q  <= caps_d;
      kdone_q <= kdone_d;
      err_q   <= rx_err;
      ascii_q <= ascii_d;
`ifdef PS2_NOREPEAT_EN
      last_code_q <= last_code_d;
      last_ext_q  <= last_ext_d;
      last_v_q    <= last_v_d;
`endif
    end
  end

  // Decoder next state: prefixes, modifiers, translation and repeat filtering
  always_comb begin
    ext_d   = ext_q;
    rel_d   = rel_q;
    shift_d = shift_q;
    caps_d  = caps_q;
    kdone_d = 1'b0;
    ascii_d = ascii_q;
    rpt_hit = 1'b0;
`ifdef PS2_NOREPEAT_EN
    last_code_d = last_code_q;
    last_ext_d  = last_ext_q;
    last_v_d    = last_v_q;
`endif
    if (byte_valid) begin
      if (code == 8'hE0) begin
        ext_d = 1'b1;
      end else if (code == 8'hF0) begin
        rel_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        rel_d = 1'b0;
        if (code == 8'h12 || code == 8'h59) begin
          shift_d = ~rel_q;
        end else if (code == 8'h58) begin
          if (!rel_q) caps_d = ~caps_q;
        end else if (!rel_q) begin
`ifdef PS2_NOREPEAT_EN
          rpt_hit     = last_v_q && last_code_q == code && last_ext_q == ext_q;
          last_code_d = code;
          last_ext_d  = ext_q;
          last_v_d    = 1'b1;
`endif
          if (map_res[8] && !rpt_hit) begin
            kdone_d = 1'b1;
            ascii_d = map_res[7:0];
          end
        end else begin
`ifdef PS2_NOREPEAT_EN
          if (last_v_q && last_code_q == code && last_ext_q == ext_q) last_v_d = 1'b0;
`endif
        end
      end
    end
  end

  assign kdone = kdone_q;
  assign ascii = ascii_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus a randomized
// key stream checked against a table-driven keyboard model.
module tb_ps2_keyboard;

  localparam int H = 4;  // system clocks per PS/2 half period

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       kdone, err;
  logic [7:0] ascii;

  ps2_keyboard #(.TIMEOUT_CYC(25000)) dut (
    .clock  (clock),
    .reset  (reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .kdone  (kdone),
    .ascii  (ascii),
    .err    (err)
  );

  always #20 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] got_q[$];
  int err_cnt = 0;
  int kd_cyc = 0;
  int fall_cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always @(negedge clock) begin
    if (kdone === 1'b1) begin
      got_q.push_back(ascii);
      kd_cyc = cyc;
    end
    if (err === 1'b1) err_cnt++;
  end

  // ---------------- reference model ----------------
  logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] DIGITS  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                               8'h46};
  string      DSHIFT = ")!@#$%^&*(";
  logic [7:0] MISC_C  [5]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  logic [7:0] MISC_A  [5]  = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
  logic [7:0] EXT_C   [5]  = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
  logic [7:0] EXT_A   [5]  = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h0D};

  bit m_ext, m_rel, m_shift, m_caps, m_last_v, m_last_ext;
  logic [7:0] m_last;
  logic [7:0] exp_q[$];

  function automatic logic [8:0] model_map(logic [7:0] c, bit ext, bit sh, bit cp);
    if (ext) begin
      for (int i = 0; i < 5; i++) if (EXT_C[i] == c) return {1'b1, EXT_A[i]};
      return '0;
    end
    for (int i = 0; i < 26; i++)
      if (LETTERS[i] == c) return {1'b1, (sh ^ cp) ? 8'(65 + i) : 8'(97 + i)};
    for (int i = 0; i < 10; i++)
      if (DIGITS[i] == c) return {1'b1, sh ? 8'(DSHIFT[i]) : 8'(48 + i)};
    for (int i = 0; i < 5; i++) if (MISC_C[i] == c) return {1'b1, MISC_A[i]};
    return '0;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [8:0] r;
    bit sup;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else begin
      if (b == 8'h12 || b == 8'h59) m_shift = !m_rel;
      else if (b == 8'h58) begin
        if (!m_rel) m_caps = !m_caps;
      end else if (m_rel) begin
`ifdef PS2_NOREPEAT_EN
        if (m_last_v && m_last == b && m_last_ext == m_ext) m_last_v = 0;
`endif
      end else begin
        r = model_map(b, m_ext, m_shift, m_caps);
        sup = 0;
`ifdef PS2_NOREPEAT_EN
        sup = m_last_v && m_last == b && m_last_ext == m_ext;
        m_last = b; m_last_ext = m_ext; m_last_v = 1;
`endif
        if (r[8] && !sup) exp_q.push_back(r[7:0]);
      end
      m_ext = 0;
      m_rel = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    repeat (H) @(posedge clock);
    #1 ps2_clk = 1'b0;
    fall_cyc = cyc;
    repeat (H) @(posedge clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad_par);
    ps2_bit(stop);
    ps2_dat = 1'b1;
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    ps2_dat = 1'b1;
  endtask

  task automatic send_list(input logic [7:0] s[$]);
    foreach (s[i]) send_frame(s[i], 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    got_q.delete();
    exp_q.delete();
    err_cnt = 0;
    m_ext = 0; m_rel = 0; m_shift = 0; m_caps = 0; m_last_v = 0; m_last_ext = 0; m_last = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    #5 reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (kdone !== 1'b0) begin n_errors++; $display("FAIL reset_kdone: got %b want 0", kdone); end
    n_checks++;
    if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++;
    if (ascii !== 8'h00) begin n_errors++; $display("FAIL reset_ascii: got %h want 00", ascii); end
    do_reset();
  endtask

  task automatic test_single_frame();
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b1);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h61) begin
      n_errors++;
      $display("FAIL single_1c: got %0d strobes first %h want 1 strobe 61", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    // two synchroniser flops then one output register after the raw stop-bit edge
    n_checks++;
    if (kd_cyc - fall_cyc != 3) begin
      n_errors++;
      $display("FAIL single_latency: got %0d cycles want 3", kd_cyc - fall_cyc);
    end
    n_checks++;
    if (err_cnt != 0) begin n_errors++; $display("FAIL single_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_shift_seq();
    logic [7:0] s[$];
    logic [7:0] e[$];
    s = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    e = '{8'h41, 8'h61};
    do_reset();
    send_list(s);
    n_checks++;
    if (got_q.size() != e.size()) begin
      n_errors++; $display("FAIL shift_count: got %0d want %0d", got_q.size(), e.size());
    end else foreach (e[i]) begin
      n_checks++;
      if (got_q[i] !== e[i]) begin
        n_errors++; $display("FAIL shift_val[%0d]: got %h want %h", i, got_q[i], e[i]);
      end
    end
  endtask

  task automatic test_caps();
    logic [7:0] s[$];
    logic [7:0] e[$];
    s = '{8'h58, 8'hF0, 8'h58, 8'h1C, 8'h16, 8'h12, 8'h16};
    e = '{8'h41, 8'h31, 8'h21};
    do_reset();
    send_list(s);
    n_checks++;
    if (got_q.size() != e.size()) begin
      n_errors++; $display("FAIL caps_count: got %0d want %0d", got_q.size(), e.size());
    end else foreach (e[i]) begin
      n_checks++;
      if (got_q[i] !== e[i]) begin
        n_errors++; $display("FAIL caps_val[%0d]: got %h want %h", i, got_q[i], e[i]);
      end
    end
  endtask

  task automatic test_errors();
    do_reset();
    send_frame(8'h1C, 1'b1, 1'b1);
    n_checks++;
    if (err_cnt != 1 || got_q.size() != 0) begin
      n_errors++;
      $display("FAIL bad_parity: got err %0d strobes %0d want 1 and 0", err_cnt, got_q.size());
    end
    send_frame(8'h1C, 1'b0, 1'b0);
    n_checks++;
    if (err_cnt != 2 || got_q.size() != 0) begin
      n_errors++;
      $display("FAIL bad_stop: got err %0d strobes %0d want 2 and 0", err_cnt, got_q.size());
    end
    err_cnt = 0;
    send_partial(8'h1C, 4);
    repeat (24985 - H) @(posedge clock);
    n_checks++;
    if (err_cnt != 0) begin n_errors++; $display("FAIL timeout_early: got %0d want 0", err_cnt); end
    repeat (40) @(posedge clock);
    #1;
    n_checks++;
    if (err_cnt != 1 || got_q.size() != 0) begin
      n_errors++;
      $display("FAIL timeout: got err %0d strobes %0d want 1 and 0", err_cnt, got_q.size());
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h61 || err_cnt != 1) begin
      n_errors++;
      $display("FAIL after_timeout: got %0d strobes err %0d want 1 strobe of 61, err 1",
               got_q.size(), err_cnt);
    end
  endtask

  task automatic test_extended();
    logic [7:0] s[$];
    s = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h11, 8'hE0, 8'h6B};
    do_reset();
    send_list(s);
    n_checks++;
    if (got_q.size() != 2) begin
      n_errors++; $display("FAIL ext_count: got %0d want 2", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== 8'h80) begin n_errors++; $display("FAIL ext_up: got %h want 80", got_q[0]); end
      n_checks++;
      if (got_q[1] !== 8'h82) begin
        n_errors++; $display("FAIL ext_left: got %h want 82", got_q[1]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b1);
    send_partial(8'h32, 3);
    #1 reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (ascii !== 8'h00 || kdone !== 1'b0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL midframe_reset: got ascii %h kdone %b err %b want 00 0 0", ascii, kdone, err);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    got_q.delete();
    err_cnt = 0;
    send_frame(8'h1C, 1'b0, 1'b1);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h61 || err_cnt != 0) begin
      n_errors++;
      $display("FAIL after_reset_frame: got %0d strobes err %0d want 1 strobe 61 err 0",
               got_q.size(), err_cnt);
    end
  endtask

  task automatic test_repeat();
    logic [7:0] s[$];
    int want;
    s = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef PS2_NOREPEAT_EN
    want = 2;
`else
    want = 4;
`endif
    do_reset();
    send_list(s);
    n_checks++;
    if (got_q.size() != want) begin
      n_errors++; $display("FAIL repeat_count: got %0d want %0d", got_q.size(), want);
    end
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== 8'h61) begin
        n_errors++; $display("FAIL repeat_val[%0d]: got %h want 61", i, got_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[$];
    logic [7:0] c;
    logic [7:0] bytes[$];
    pool = '{8'h12, 8'h59, 8'h58, 8'h05, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    foreach (LETTERS[i]) pool.push_back(LETTERS[i]);
    foreach (DIGITS[i]) pool.push_back(DIGITS[i]);
    do_reset();
    for (int ev = 0; ev < 70; ev++) begin
      bytes.delete();
      if ($urandom_range(0, 4) == 0) begin
        bytes.push_back(8'hE0);
        c = ($urandom_range(0, 5) == 5) ? 8'h11 : EXT_C[$urandom_range(0, 4)];
      end else begin
        c = pool[$urandom_range(0, pool.size() - 1)];
      end
      if ($urandom_range(0, 2) == 0) bytes.push_back(8'hF0);
      bytes.push_back(c);
      foreach (bytes[i]) begin
        model_byte(bytes[i]);
        send_frame(bytes[i], 1'b0, 1'b1);
      end
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL rand_val[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (err_cnt != 0) begin n_errors++; $display("FAIL rand_err: got %0d want 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_shift_seq();
    test_caps();
    test_errors();
    test_extended();
    test_reset_midframe();
    test_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- PS/2 keyboard front end, directly upstream of the port block.
- Receives device-to-host frames on ps2_clk/ps2_dat and tracks make/break/E0 prefixes, Shift and Caps Lock.
- Translates set-2 scan codes to ASCII.
- Emits a one-cycle kdone strobe with the ascii byte; these drive p_kdone/p_ascii of the port block.

Parameters:
- TIMEOUT_CYC, 25000, idle clocks allowed between PS/2 falling edges mid-frame; 1 ms at the 25 MHz system clock.

Ports:
- clock  in  1  system clock, 25 MHz
- reset  in  1  asynchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock line, asynchronous
- ps2_dat  in  1  raw PS/2 data line, asynchronous
- kdone  out  1  one-cycle strobe: ascii holds a new key
- ascii  out  8  translated key code; stable between strobes
- err  out  1  one-cycle strobe on framing, parity or timeout error

Behaviour:
- Reset: asynchronous, active-high; clock and reset fixed as above.
  - Reset values: kdone=0, err=0, ascii=00h.
  - Clears shift, caps, release and extended flags; receiver returns to IDLE; synchroniser flops are set to 1.
- Input sync: 2-flop synchroniser on each line. A falling edge is synced ps2_clk previous=1, current=0. Data is sampled on the synced value in that same cycle.
- Receiver FSM (bit counter 0..7, shift register LSB first, running parity):
  - IDLE: on an edge with dat=0, go to DATA. With dat=1, stay in IDLE and pulse err.
  - DATA: 8 edges shift in d0..d7, then go to PARITY.
  - PARITY: capture the bit. The frame must have odd parity over d0..d7 plus the parity bit.
  - STOP: the bit must be 1 and the parity check must be good; then the byte is valid for one cycle. Otherwise pulse err and discard. Return to IDLE in both cases.
  - Timeout: in any state other than IDLE, TIMEOUT_CYC clocks without an edge returns to IDLE, discards the partial frame and pulses err. The counter clears on every edge.
- Decoder (acts on each valid byte):
  - E0h: set ext. F0h: set rel. No output for either.
  - Any other byte: process the code, then clear ext and rel.
  - 12h/59h (L/R Shift): shift = !rel.
  - 58h (Caps) make: toggle caps. Break: no action.
  - If rel is set: no output.
  - Make of a mapped key: ascii <= code and kdone=1 in the clock after the stop-bit edge, i.e. latency 1 cycle from the valid byte.
  - Unmapped make: no strobe, ascii unchanged.
- Map for non-ext codes:
  - Letters 1Ch,32h,21h,23h,24h,2Bh,34h,33h,43h,3Bh,42h,4Bh,3Ah,31h,44h,4Dh,15h,2Dh,1Bh,2Ch,3Ch,2Ah,1Dh,22h,35h,1Ah map to a..z. Uppercase when shift XOR caps.
  - Digits 45h,16h,1Eh,26h,25h,2Eh,36h,3Dh,3Eh,46h map to '0'..'9'. With shift they map to ")!@#$%^&*(" respectively; caps has no effect.
  - 29h→20h, 5Ah→0Dh, 66h→08h, 0Dh→09h, 76h→1Bh.
- Map for ext codes: 75h→80h (up), 72h→81h (down), 6Bh→82h (left), 74h→83h (right). E0 5Ah→0Dh. Other ext codes are unmapped.
- Back-to-back: the consumer latches on the strobe, so no backpressure is needed. Strobes are at least one full PS/2 frame apart.
- Reset mid-frame: the partial frame is lost and no kdone is produced.

Optional Feature:
- PS2_NOREPEAT_EN defined:
  - Store the last make code together with its ext flag.
  - A make identical to the stored code is suppressed, so typematic repeat produces no kdone.
  - A break of the stored code clears the store. Any different make replaces it.
  - Shift and Caps are never stored.
- PS2_NOREPEAT_EN undefined: every mapped make, including typematic repeats, strobes kdone.

Test Plan:
- Frame 1Ch, parity 0, stop 1 → one kdone, ascii=61h one cycle after the stop edge; err=0.
- Sequence 12h, 1Ch, F0 1Ch, F0 12h, 1Ch → kdone with 41h, then kdone with 61h; the breaks produce no strobe.
- 58h, F0 58h, then 1Ch and 16h → ascii 41h then 31h; with shift held, 16h gives 21h.
- Frame 1Ch with parity=1 → err pulse, no kdone. A frame with stop=0 → err pulse. Stall after 4 data bits for 25000 clocks → err, FSM back to IDLE, next good frame decodes.
- E0 75h → ascii=80h. E0 F0 75h → no strobe. Assert reset mid-frame → outputs 00h/0, next frame decodes normally.
- PS2_NOREPEAT_EN defined: 1Ch ×3 then F0 1Ch, then 1Ch → exactly 2 kdone strobes. Macro undefined: 4 strobes.
